fifo_demux_1_2: RTL
===================

Name: fifo_demux_1_2

Overview:
- Write-side steering block for the array's FIFOs: a 2-entry ping-pong buffer.
- A 1:2 demultiplexer driven by a toggling write pointer routes each accepted input word into one of two bank registers.
- The read side pops words in arrival order through a read pointer.
- Serves as the shallow elastic stage between the L0/input FIFOs and the PE rows when a full-depth FIFO is unnecessary.

Parameters:
- bw, 8, data width of one word in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  bw  write data.
- wr  input  1  write request; accepted only when o_full=0.
- rd  input  1  read request; accepted only when o_empty=0.
- out  output  bw  head word, bank[rd_ptr]. Combinational from registers; no read latency.
- o_full  output  1  both banks occupied.
- o_empty  output  1  no bank occupied.
- o_count  output  2  number of occupied banks, 0..2.
- o_wr_sel  output  1  current write pointer (bank the next write lands in); exported for debug.

Behaviour:
- State: bank0/bank1 (bw bits each), valid0/valid1, wr_ptr, rd_ptr.
- Asynchronous reset clears all state to 0, so out=0, o_full=0, o_empty=1, o_count=0, o_wr_sel=0.
- Reset asserted mid-operation discards stored words immediately, without waiting for a clock edge.
- Write acceptance: wr_acc = wr & ~o_full, where o_full is the pre-edge value.
  - On a clock edge with wr_acc=1: bank[wr_ptr] <= in, valid[wr_ptr] <= 1, wr_ptr <= ~wr_ptr.
- Read acceptance: rd_acc = rd & ~o_empty, where o_empty is the pre-edge value.
  - On a clock edge with rd_acc=1: valid[rd_ptr] <= 0, rd_ptr <= ~rd_ptr.
  - Bank data is not cleared on a read.
- Write while full: ignored. No state change; the word is lost unless the source holds it. The source must gate on o_full.
- Read while empty: ignored. Pointers do not move; out shows the stale bank[rd_ptr].
- Simultaneous wr and rd:
  - count=1: both accepted; count stays 1; the pointers move together.
  - count=0: only the write is accepted; count becomes 1. No write-through bypass, so data appears on out one cycle after the write edge.
  - count=2: only the read is accepted; count becomes 1. The write is dropped.
- Flag derivation:
  - o_full = valid0 & valid1.
  - o_empty = ~(valid0 | valid1).
  - o_count = valid0 + valid1.
- Invariant: at most one write and one read per cycle, and they never target the same bank when count=1.
- Latency: write to visible on out is 1 cycle when empty; pop to next word is 0 cycles, as out updates after the edge.

Optional Feature:
- Macro: FIFO_DEMUX_ERR_EN.
- Defined:
  - Adds output o_err[1:0]. bit0 is sticky overflow, set by wr & o_full. bit1 is sticky underflow, set by rd & o_empty.
  - Both bits are cleared only by reset.
  - Rejected accesses still have no other effect.
- Undefined: the port and its logic are absent; illegal accesses are silently ignored.

Decomposition:
- Shared package fifo_pkg:
  - constant FIFO_BW_DEFAULT=8.
  - typedef for the 2-bit count.
  - localparams BANK0=0, BANK1=1.
- One natural sub-module, fifo_bank_reg: bw-bit register with asynchronous active-high reset and load enable.
  - Instantiated twice.
  - Enable for bank i = wr_acc & (wr_ptr==i).
- Read-side selection is inline in the top level.

Test Plan:
- Reset mid-fill: write 0xA1, assert reset between edges -> o_empty=1, o_count=0 and out=0 immediately, before the next edge.
- Ordered fill/drain: write 0x11 then 0x22 -> o_full=1, o_count=2, out=0x11. rd -> out=0x22. rd -> o_empty=1.
- Overflow: at full (0x11, 0x22), wr with 0x33 -> contents unchanged. Two reads return 0x11, 0x22. With FIFO_DEMUX_ERR_EN defined, o_err=2'b01.
- Underflow: at empty, rd -> no pointer movement; a following write 0x44 is read back as 0x44. With the macro defined, o_err[1]=1.
- Simultaneous at count=1 (holding 0x55): wr 0x66 with rd -> o_count=1, out=0x66. Repeat for 8 cycles with incrementing data; every read returns write order and pointers wrap cleanly.
- Simultaneous at count=0: wr 0x77 with rd -> next cycle o_count=1, out=0x77.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 2-entry ping-pong FIFO steering block.
package fifo_pkg;

  localparam int FIFO_BW_DEFAULT = 8;

  // Occupancy count of the two banks (0..2).
  typedef logic [1:0] count_t;

  // Bank indices addressed by the write and read pointers.
  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/fifo_bank_reg.sv
// One storage bank of the ping-pong buffer: a bw-bit register with load enable.
module fifo_bank_reg #(
  parameter int bw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [bw-1:0] d,
  output logic [bw-1:0] q
);

  // Capture the incoming word when this bank is the write target.
  // NOTE: bank data is reset as well, so the head word reads 0 out of reset
  // instead of X; a read never clears it, which is why stale data can show.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignment keeps every register updating from
      // pre-edge values, independent of always-block evaluation order.
      q <= d;
    end
  end

endmodule

// File: rtl/fifo_demux_1_2.sv
// 2-entry ping-pong FIFO: a toggling write pointer steers each accepted word
// into one of two banks; a toggling read pointer pops them in arrival order.
// Optional feature: define FIFO_DEMUX_ERR_EN to add sticky o_err[1:0]
// (bit0 = overflow, bit1 = underflow).
module fifo_demux_1_2
  import fifo_pkg::*;
#(
  parameter int bw = FIFO_BW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] in,
  input  logic          wr,
  input  logic          rd,
  output logic [bw-1:0] out,
  output logic          o_full,
  output logic          o_empty,
  output count_t        o_count,
  output logic          o_wr_sel
`ifdef FIFO_DEMUX_ERR_EN
  ,
  output logic [1:0]    o_err
`endif
);

  logic [1:0]    valid;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic [bw-1:0] bank0;
  logic [bw-1:0] bank1;

  // Flags come straight from the valid bits, so they are pre-edge values
  // when the acceptance terms below are evaluated at the clock edge.
  assign o_full   = valid[0] & valid[1];
  assign o_empty  = ~(valid[0] | valid[1]);
  assign o_count  = count_t'({1'b0, valid[0]} + {1'b0, valid[1]});
  assign o_wr_sel = wr_ptr;

  // Writes are refused when full and reads when empty; with count=1 both
  // are accepted and always target different banks.
  assign wr_acc = wr & ~o_full;
  assign rd_acc = rd & ~o_empty;

  fifo_bank_reg #(.bw(bw)) u_bank0 (
    .clk   (clk),
    .reset (reset),
    .load  (wr_acc & (wr_ptr == BANK0)),
    .d     (in),
    .q     (bank0)
  );

  fifo_bank_reg #(.bw(bw)) u_bank1 (
    .clk   (clk),
    .reset (reset),
    .load  (wr_acc & (wr_ptr == BANK1)),
    .d     (in),
    .q     (bank1)
  );

  // Head word is selected combinationally; no read latency.
  assign out = (rd_ptr == BANK1) ? bank1 : bank0;

  // Occupancy and pointer bookkeeping for accepted writes and reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= '0;
      wr_ptr <= BANK0;
      rd_ptr <= BANK0;
    end else begin
      if (wr_acc) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= ~wr_ptr;
      end
      if (rd_acc) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= ~rd_ptr;
      end
    end
  end

`ifdef FIFO_DEMUX_ERR_EN
  // Sticky overflow/underflow flags; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_err <= '0;
    end else begin
      if (wr & o_full)  o_err[0] <= 1'b1;
      if (rd & o_empty) o_err[1] <= 1'b1;
    end
  end
`endif

endmodule
